// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs, FSM states,
// datapath select codes and the registered control-output bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_JUMP = 2'b01;
  localparam logic [1:0] PC_REGA = 2'b10;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] RIN_ALU = 2'b00;
  localparam logic [1:0] RIN_MEM = 2'b01;
  localparam logic [1:0] RIN_PC4 = 2'b10;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
  } icls_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       pc_we;
    logic [1:0] pc_next;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic       reg_we;
    logic [1:0] reg_in;
    logic       beq;
    logic       bne;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake between the controller (master) and memory (slave).
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;

  modport master (output mem_req, output mem_we, input instr, input mem_ack);
  modport slave  (input mem_req, input mem_we, output instr, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational IR decoder: instruction class, ALU operand/operation and legality.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output icls_t       cls,
  output logic        alu_src,
  output logic [1:0]  alu_ctrl,
  output logic        legal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op            = ir[31:26];
  assign fn            = ir[5:0];
  assign unused_fields = ^ir[25:6];

  always_comb begin
    cls      = C_ILL;
    alu_src  = 1'b0;
    alu_ctrl = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  begin cls = C_ALU_R; alu_src = 1'b1; alu_ctrl = ALU_ADD; end
          FN_SUB:  begin cls = C_ALU_R; alu_src = 1'b1; alu_ctrl = ALU_SUB; end
          FN_SLT:  begin cls = C_ALU_R; alu_src = 1'b1; alu_ctrl = ALU_SLT; end
          FN_XOR:  begin cls = C_ALU_R; alu_src = 1'b1; alu_ctrl = ALU_XOR; end
          FN_JR:   cls = C_JR;
          default: cls = C_ILL;
        endcase
      end
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  begin cls = C_BEQ; alu_src = 1'b1; alu_ctrl = ALU_SUB; end
      OP_BNE:  begin cls = C_BNE; alu_src = 1'b1; alu_ctrl = ALU_SUB; end
      OP_ADDI: cls = C_ALU_I;
      OP_XORI: begin cls = C_ALU_I; alu_ctrl = ALU_XOR; end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end

  assign legal = (cls != C_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller (Moore FSM, registered outputs).
// Define MULTICYCLE_CTRL_TRAP_EN to trap on illegal instructions instead of retiring them as NOPs.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_if.master      bus,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic [1:0]             pc_next,
  output logic [1:0]             reg_dst,
  output logic                   alu_src,
  output logic [1:0]             alu_ctrl,
  output logic                   reg_we,
  output logic [1:0]             reg_in,
  output logic                   beq,
  output logic                   bne,
  output logic                   trap
);

`ifdef MULTICYCLE_CTRL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  state_t      state;
  logic [31:0] ir;
  ctrl_out_t   out_q;
  icls_t       cls;
  logic        dec_alu_src;
  logic [1:0]  dec_alu_ctrl;
  logic        legal;

  ctrl_decode u_decode (
    .ir       (ir),
    .cls      (cls),
    .alu_src  (dec_alu_src),
    .alu_ctrl (dec_alu_ctrl),
    .legal    (legal)
  );

  function automatic state_t step(state_t s, logic ack, icls_t c);
    state_t n;
    n = s;
    case (s)
      S_IDLE:   n = S_FETCH;
      S_FETCH:  if (ack) n = S_DECODE;
      S_DECODE: n = (TRAP_ON && c == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (c)
          C_LW, C_SW:       n = S_MEM;
          C_ALU_R, C_ALU_I: n = S_WB;
          default:          n = S_FETCH;
        endcase
      end
      S_MEM:    if (ack) n = (c == C_LW) ? S_WB : S_FETCH;
      S_WB:     n = S_FETCH;
      S_TRAP:   n = S_TRAP;
      default:  n = S_IDLE;
    endcase
    return n;
  endfunction

  // Output pattern of a state; IR is stable across every state that uses it.
  function automatic ctrl_out_t moore(state_t s, icls_t c, logic lg,
                                      logic as, logic [1:0] ac);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_FETCH: o.mem_req = 1'b1;
      S_EXEC: begin
        o.alu_src  = as;
        o.alu_ctrl = ac;
        o.beq      = (c == C_BEQ);
        o.bne      = (c == C_BNE);
        o.pc_we    = !lg || (c inside {C_BEQ, C_BNE, C_J, C_JAL, C_JR});
        if (c == C_J || c == C_JAL) o.pc_next = PC_JUMP;
        if (c == C_JR)              o.pc_next = PC_REGA;
        if (c == C_JAL) begin
          o.reg_we  = 1'b1;
          o.reg_dst = DST_R31;
          o.reg_in  = RIN_PC4;
        end
      end
      S_MEM: begin
        o.mem_req = 1'b1;
        o.mem_we  = (c == C_SW);
      end
      S_WB: begin
        o.alu_src  = as;
        o.alu_ctrl = ac;
        o.reg_we   = 1'b1;
        o.pc_we    = 1'b1;
        o.pc_next  = PC_SEQ;
        o.reg_in   = (c == C_LW)    ? RIN_MEM : RIN_ALU;
        o.reg_dst  = (c == C_ALU_R) ? DST_RD  : DST_RT;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
      out_q <= '0;
    end else begin
      state <= step(state, bus.mem_ack, cls);
      out_q <= moore(step(state, bus.mem_ack, cls), cls, legal, dec_alu_src, dec_alu_ctrl);
      if (state == S_FETCH && bus.mem_ack) ir <= bus.instr;
    end
  end

  // Strobes that complete a handshake must fire in the ack cycle itself.
  assign ir_we       = (state == S_FETCH) && bus.mem_ack;
  assign pc_we       = out_q.pc_we || ((state == S_MEM) && (cls == C_SW) && bus.mem_ack);
  assign bus.mem_req = out_q.mem_req;
  assign bus.mem_we  = out_q.mem_we;
  assign pc_next     = out_q.pc_next;
  assign reg_dst     = out_q.reg_dst;
  assign alu_src     = out_q.alu_src;
  assign alu_ctrl    = out_q.alu_ctrl;
  assign reg_we      = out_q.reg_we;
  assign reg_in      = out_q.reg_in;
  assign beq         = out_q.beq;
  assign bne         = out_q.bne;

`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= (step(state, bus.mem_ack, cls) == S_TRAP);
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output traces
// plus hand-computed retire vectors and cycle counts.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  logic       ir_we, pc_we, alu_src, reg_we, beq, bne, trap;
  logic [1:0] pc_next, reg_dst, alu_ctrl, reg_in;

  multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_next  (pc_next),
    .reg_dst  (reg_dst),
    .alu_src  (alu_src),
    .alu_ctrl (alu_ctrl),
    .reg_we   (reg_we),
    .reg_in   (reg_in),
    .beq      (beq),
    .bne      (bne),
    .trap     (trap)
  );

  // {mem_req, mem_we, ir_we, pc_we, pc_next, reg_dst, alu_src, alu_ctrl, reg_we, reg_in, beq, bne, trap}
  logic [16:0] got;
  assign got = {bus.mem_req, bus.mem_we, ir_we, pc_we, pc_next, reg_dst,
                alu_src, alu_ctrl, reg_we, reg_in, beq, bne, trap};

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];
  logic [31:0] cur_word;
  int          lat_f, lat_m, cnt, phase, cyc, ret_cyc, n_pcwe;
  bit          tied;
  logic [16:0] ret_vec;

  function automatic logic [16:0] mk(logic rq, logic we, logic iw, logic pw,
                                     logic [1:0] pn, logic [1:0] rd, logic as,
                                     logic [1:0] ac, logic rw, logic [1:0] ri,
                                     logic bq, logic bn, logic tr);
    return {rq, we, iw, pw, pn, rd, as, ac, rw, ri, bq, bn, tr};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Expected trace of one instruction, straight from the per-instruction cycle rules.
  task automatic build(logic [31:0] w, int lf, int lm);
    logic [5:0] op, fn;
    bit r, ii, lw, sw, bq, bn, jj, jal, jr, ill;
    logic as;
    logic [1:0] ac;
    op = w[31:26]; fn = w[5:0];
    {r, ii, lw, sw, bq, bn, jj, jal, jr, ill} = '0;
    as = 1'b0; ac = 2'b00;
    case (op)
      6'h00: case (fn)
        6'h20:   begin r = 1; as = 1; ac = 2'b00; end
        6'h22:   begin r = 1; as = 1; ac = 2'b01; end
        6'h2A:   begin r = 1; as = 1; ac = 2'b10; end
        6'h26:   begin r = 1; as = 1; ac = 2'b11; end
        6'h08:   jr = 1;
        default: ill = 1;
      endcase
      6'h23:   lw = 1;
      6'h2B:   sw = 1;
      6'h04:   begin bq = 1; as = 1; ac = 2'b01; end
      6'h05:   begin bn = 1; as = 1; ac = 2'b01; end
      6'h08:   ii = 1;
      6'h0E:   begin ii = 1; ac = 2'b11; end
      6'h02:   jj = 1;
      6'h03:   jal = 1;
      default: ill = 1;
    endcase
    for (int i = 0; i < lf; i++) exp_q.push_back(mk(1,0,0,0,2'b00,2'b00,0,2'b00,0,2'b00,0,0,0));
    exp_q.push_back(mk(1,0,1,0,2'b00,2'b00,0,2'b00,0,2'b00,0,0,0));
    exp_q.push_back('0);
    if (ill && TRAP) begin
      repeat (6) exp_q.push_back(mk(0,0,0,0,2'b00,2'b00,0,2'b00,0,2'b00,0,0,1));
      return;
    end
    exp_q.push_back(mk(0, 0, 0, ill | bq | bn | jj | jal | jr,
                       (jj | jal) ? 2'b01 : (jr ? 2'b10 : 2'b00),
                       jal ? 2'b10 : 2'b00, as, ac, jal,
                       jal ? 2'b10 : 2'b00, bq, bn, 0));
    if (lw | sw) begin
      for (int i = 0; i < lm; i++) exp_q.push_back(mk(1,sw,0,0,2'b00,2'b00,0,2'b00,0,2'b00,0,0,0));
      exp_q.push_back(mk(1,sw,0,sw,2'b00,2'b00,0,2'b00,0,2'b00,0,0,0));
    end
    if (lw | r | ii)
      exp_q.push_back(mk(0,0,0,1,2'b00, r ? 2'b01 : 2'b00, as, ac, 1,
                         lw ? 2'b01 : 2'b00, 0,0,0));
  endtask

  // One clock: act as memory on the falling edge, then compare against the trace.
  task automatic cycle();
    logic [16:0] e;
    int lat;
    @(negedge clk);
    lat = (phase == 0) ? lat_f : lat_m;
    if (bus.mem_req) begin
      if (cnt >= lat) begin bus.mem_ack = 1'b1; cnt = 0; phase++; end
      else begin bus.mem_ack = 1'b0; cnt++; end
    end else begin
      bus.mem_ack = tied;
    end
    bus.instr = (bus.mem_ack || tied) ? cur_word : 32'hFC00_0000;
    #1;
    cyc++;
    e = exp_q.pop_front();
    check($sformatf("trace_%h_cyc%0d", cur_word, cyc), {15'd0, got}, {15'd0, e});
    if (pc_we) begin n_pcwe++; ret_cyc = cyc; ret_vec = got; end
  endtask

  task automatic run_instr(logic [31:0] w, int lf, int lm, bit t);
    cur_word = w; lat_f = lf; lat_m = lm; tied = t;
    cnt = 0; phase = 0; cyc = 0; n_pcwe = 0; ret_cyc = 0; ret_vec = '0;
    build(w, lf, lm);
    while (exp_q.size() > 0) cycle();
  endtask

  task automatic retire_chk(string nm, int cycles, logic [16:0] vec);
    check({nm, "_pcwe_count"}, n_pcwe, 32'd1);
    check({nm, "_cycles"}, ret_cyc, cycles);
    check({nm, "_retire_vec"}, {15'd0, ret_vec}, {15'd0, vec});
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.mem_ack = 1'b0;
    cur_word = '0; tied = 0; lat_f = 0; lat_m = 0; cnt = 0; phase = 0; cyc = 0;
    exp_q.delete();
    exp_q.push_back('0);
    cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.instr = '0; reset = 1'b1;
    #1 check("reset_outs", {15'd0, got}, 32'd0);
    release_reset();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; bus.mem_ack = 1'b0; bus.instr = '0;
    do_reset();

    run_instr(32'h012A_4020, 0, 0, 1); retire_chk("add_tied", 4, 17'h02320);
    run_instr(32'h012A_4022, 0, 0, 1); retire_chk("sub_tied", 4, 17'h02360);
    run_instr(32'h012A_402A, 2, 0, 0);
    run_instr(32'h012A_4026, 1, 0, 0);
    run_instr(32'h2109_0005, 1, 0, 0);
    run_instr(32'h3909_00FF, 0, 0, 1);
    run_instr(32'h8D09_0004, 0, 0, 0); retire_chk("lw", 5, 17'h02028);
    run_instr(32'h8D09_0004, 1, 2, 0); retire_chk("lw_wait", 8, 17'h02028);
    run_instr(32'hAD09_0008, 0, 0, 0); retire_chk("sw", 4, 17'h1A000);
    run_instr(32'hAD09_0008, 0, 1, 0);
    run_instr(32'h1109_0003, 0, 0, 0); retire_chk("beq", 3, 17'h02144);
    run_instr(32'h1509_0003, 0, 0, 1); retire_chk("bne", 3, 17'h02142);
    run_instr(32'h0800_0020, 0, 0, 0); retire_chk("j", 3, 17'h02800);
    run_instr(32'h0C00_0010, 0, 0, 1); retire_chk("jal", 3, 17'h02C30);
    run_instr(32'h0100_0008, 0, 0, 0); retire_chk("jr", 3, 17'h03000);

    // Reset while a fetch is still waiting for its acknowledge.
    cur_word = 32'h012A_4020; lat_f = 5; lat_m = 0; tied = 0; cnt = 0; phase = 0; cyc = 0;
    exp_q.delete();
    repeat (2) exp_q.push_back(mk(1,0,0,0,2'b00,2'b00,0,2'b00,0,2'b00,0,0,0));
    cycle(); cycle();
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #2 reset = 1'b1; bus.mem_ack = 1'b1; bus.instr = cur_word;
    #1;
    check("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mid_ir_we", {31'd0, ir_we}, 32'd0);
    check("rst_mid_outs", {15'd0, got}, 32'd0);
    release_reset();
    run_instr(32'h012A_4020, 0, 0, 0); retire_chk("add_after_rst", 4, 17'h02320);

`ifdef MULTICYCLE_CTRL_TRAP_EN
    run_instr(32'hFC00_0000, 0, 0, 0);
    check("trap_op_no_retire", n_pcwe, 32'd0);
    check("trap_op_held", {31'd0, trap}, 32'd1);
    do_reset();
    run_instr(32'h012A_4021, 1, 0, 0);
    check("trap_fn_no_retire", n_pcwe, 32'd0);
    check("trap_fn_held", {31'd0, trap}, 32'd1);
    do_reset();
    run_instr(32'h012A_4020, 0, 0, 0); retire_chk("add_after_trap", 4, 17'h02320);
`else
    run_instr(32'hFC00_0000, 0, 0, 0); retire_chk("illegal_op_nop", 3, 17'h02000);
    run_instr(32'h012A_4021, 1, 0, 0); retire_chk("illegal_fn_nop", 4, 17'h02000);
    run_instr(32'h012A_4020, 0, 0, 0); retire_chk("add_after_nop", 4, 17'h02320);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
